// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR output path.
// Accumulator and sample widths are fixed here for every FIR block.
package fir_pkg;

    localparam int ACC_W  = 38;
    localparam int DATA_W = 16;
    localparam int TAPS   = 64;

    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [DATA_W-1:0] sample_t;

    typedef struct packed {
        logic    valid;
        sample_t data;
    } q_stage_t;

endpackage

// File: rtl/fir_out_fifo.sv
// Output sample FIFO, first-word-fall-through head, power-of-two depth.
// Head reads as zero while empty so downstream never sees stale storage.
module fir_out_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_level;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == (AW+1)'(DEPTH));
    assign w_pop   = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still take a push.
    assign w_push  = i_push & (~w_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;

endmodule

// File: rtl/fir_out_quantizer.sv
// FIR output stage: round, shift and narrow the accumulator, then buffer.
// Optional clamp to the 16-bit range and sat pulse with FIR_OUT_SAT_EN.
module fir_out_quantizer
    import fir_pkg::*;
#(
    parameter int SHIFT = 15,
    parameter int DEPTH = 8
) (
    input  logic                   clk1,
    input  logic                   rst,
    input  acc_t                   sum_in,
    input  logic                   sum_valid,
    output logic                   sum_ready,
    output sample_t                dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   ovf,
    output logic [$clog2(DEPTH):0] level
`ifdef FIR_OUT_SAT_EN
    ,
    output logic                   sat
`endif
);

    localparam int   LVL_W = $clog2(DEPTH) + 1;
    localparam acc_t RND   = acc_t'(2 ** (SHIFT - 1));

    q_stage_t         r_s1;
    logic             r_ovf;
    acc_t             w_rnd;
    acc_t             w_q;
    sample_t          w_narrow;
    logic             w_accept;
    logic             w_full;
    logic             w_empty;
    logic [LVL_W-1:0] w_level;
    logic [LVL_W:0]   w_occ;
    sample_t          w_head;

    assign w_rnd = sum_in + RND;
    assign w_q   = w_rnd >>> SHIFT;

`ifdef FIR_OUT_SAT_EN
    localparam acc_t    Q_HI = acc_t'(2 ** (DATA_W - 1) - 1);
    localparam acc_t    Q_LO = -Q_HI - acc_t'(1);
    localparam sample_t S_HI = sample_t'(2 ** (DATA_W - 1) - 1);
    localparam sample_t S_LO = -S_HI - sample_t'(1);

    logic w_hi;
    logic w_lo;
    logic r_s1_clip;
    logic r_sat;

    assign w_hi = (w_q > Q_HI);
    assign w_lo = (w_q < Q_LO);

    always_comb begin
        w_narrow = sample_t'(w_q);
        if (w_hi)      w_narrow = S_HI;
        else if (w_lo) w_narrow = S_LO;
    end

    // sat marks the edge where a clamped sample lands in the FIFO.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_s1_clip <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            if (w_accept) r_s1_clip <= w_hi | w_lo;
            r_sat <= r_s1.valid & r_s1_clip;
        end
    end

    assign sat = r_sat;
`else
    assign w_narrow = sample_t'(w_q);
`endif

    // Stage 1 plus FIFO occupancy is what bounds acceptance.
    assign w_occ     = {1'b0, w_level} + (LVL_W+1)'(r_s1.valid);
    assign sum_ready = ~w_full & (w_occ < (LVL_W+1)'(DEPTH));
    assign w_accept  = sum_valid & sum_ready;

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_s1  <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_s1.valid <= w_accept;
            if (w_accept)              r_s1.data <= w_narrow;
            if (sum_valid & ~sum_ready) r_ovf    <= 1'b1;
        end
    end

    fir_out_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .i_clk   (clk1),
        .i_rst   (rst),
        .i_push  (r_s1.valid),
        .i_data  (r_s1.data),
        .i_pop   (dout_ready),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign dout       = w_head;
    assign dout_valid = ~w_empty;
    assign ovf        = r_ovf;
    assign level      = w_level;

endmodule

// File: doc/fir_out_quantizer.md
FIR_OUT_QUANTIZER -- requirements
Module: fir_out_quantizer

Interface
REQ-001 Parameter SHIFT, default 15: right-shift applied to the 38-bit accumulator sum, i.e. the Q-format drop.
REQ-002 Parameter DEPTH, default 8: output FIFO entries; a power of two, minimum 2.
REQ-003 Port clk1, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port sum_in, input, 38: signed accumulator result from the FIR core.
REQ-006 Port sum_valid, input, 1: sum_in holds a new result this cycle.
REQ-007 Port sum_ready, output, 1: block can accept sum_in this cycle.
REQ-008 Port dout, output, 16: signed quantized sample at the FIFO head.
REQ-009 Port dout_valid, output, 1: dout is valid (FIFO not empty).
REQ-010 Port dout_ready, input, 1: consumer takes dout this cycle.
REQ-011 Port ovf, output, 1: sticky flag; a result was presented while sum_ready=0.
REQ-012 Port level, output, $clog2(DEPTH)+1: FIFO occupancy.

Function
REQ-013 Accept: a result is accepted when sum_valid=1 and sum_ready=1.
REQ-014 Quantize (stage 1, registered): r = (sum_in + 2^(SHIFT-1)) >>> SHIFT; arithmetic shift; round-half-up; 38-bit intermediate with no overflow.
REQ-015 Narrowing to 16 bits per the Configuration section.
REQ-016 Latency: an accepted result is written to the FIFO on the next edge and appears on dout with dout_valid=1 two edges after acceptance when the FIFO was empty.
REQ-017 sum_ready = (level + stage1_valid) < DEPTH; combinational from registers only.
REQ-018 Drop: sum_valid=1 with sum_ready=0 discards the sample, sets ovf=1, and leaves FIFO contents unchanged.
REQ-019 ovf stays set until rst.
REQ-020 Pop: occurs when dout_valid=1 and dout_ready=1; dout_ready while empty is ignored.
REQ-021 Simultaneous push and pop: level is unchanged.
REQ-022 Push and pop when full: legal, because the pop frees the slot in the same cycle.
REQ-023 Pointers: wrap modulo DEPTH; FIFO order is strict first-in, first-out.
REQ-024 dout is first-word-fall-through: it equals the head entry whenever dout_valid=1.

Reset
REQ-025 rst=1 at an edge: level=0, pointers=0, stage1_valid=0, dout=0, dout_valid=0, ovf=0, sum_ready=1 after that edge.
REQ-026 Reset mid-operation discards all buffered and in-flight samples.
REQ-027 sum_valid is ignored during reset cycles.
REQ-028 FIFO storage contents need no reset; dout is forced to 0 while empty.

Configuration
REQ-029 Macro FIR_OUT_SAT_EN defined: r is clamped to [-32768, 32767].
REQ-030 FIR_OUT_SAT_EN defined: extra output sat, 1 bit, pulses high for one cycle at the FIFO write of a clamped sample; reset value 0.
REQ-031 FIR_OUT_SAT_EN undefined: dout = r[15:0] (two's-complement wrap), and port sat does not exist.

Structure
REQ-032 Shared package fir_pkg holds:
- constants ACC_W=38, DATA_W=16, TAPS=64
- typedefs acc_t (signed ACC_W) and sample_t (signed DATA_W)
REQ-033 FIFO is a sub-module fir_out_fifo (DEPTH, DATA_W); it provides push, pop, full, empty, level, and first-word-fall-through head.
REQ-034 Quantize/round/saturate logic lives in the top level.

Verification (SHIFT=15, DEPTH=8)
REQ-035 Rounding: sum_in 32768, 16384, 16383, -16384, -16385, each single-cycle valid -> dout 1, 1, 0, 0, -1 in order, first one 2 cycles after acceptance.
REQ-036 Saturation: sum_in 2^31 -> dout 32767 with sat pulse (SAT_EN); dout 0 with no sat port (no SAT_EN). sum_in -2^31 -> -32768 (SAT_EN) / 0 (no SAT_EN).
REQ-037 Fill: dout_ready=0, 10 consecutive valid results -> 8 stored, level=8, sum_ready=0 once level+stage1_valid=8, ovf=1. Then drain: 8 pops return the first 8 values in order.
REQ-038 Streaming: continuous sum_valid and dout_ready=1 for 100 cycles -> level never exceeds 2, no drops, ovf=0, output sequence equals input quantized in order.
REQ-039 Full plus simultaneous pop: level=8, then one push and one pop in the same cycle -> level stays 8, the new sample is at the tail, ovf=0.
REQ-040 Reset mid-stream: rst asserted with level=5 -> next cycle level=0, dout_valid=0, dout=0, ovf=0, sum_ready=1.
